// File: rtl/pair_triple_event_counter_pkg.sv
// Shared types and constants for the pair/triple event counter slice.
package pair_triple_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int RUN_W        = 4;
  localparam int DEBOUNCE_MIN = 1;
  localparam int DEBOUNCE_MAX = 15;
  localparam int CNT_W_MIN    = 2;
  localparam int CNT_W_MAX    = 16;

  // 2-of-3 majority: true when at least two inputs are high.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/pair_triple_event_counter_if.sv
// Report channel: valid/ready handshake carrying the latest event count.
interface pair_triple_event_counter_if #(
  parameter int CNT_W = 8
) ();
  logic             out_val;
  logic             out_rdy;
  logic [CNT_W-1:0] out_count;

  modport master (output out_val, output out_count, input out_rdy);
  modport slave  (input out_val, input out_count, output out_rdy);
endinterface

// File: rtl/pair_triple_event_counter_debounce.sv
// Samples the raw inputs, forms the majority and debounces it with a
// run-length FSM. fire_o is a single-cycle pulse, valid for the edge at
// which the qualifying sample completes the run.
module pair_triple_debounce
  import pair_triple_event_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clear_i,
  input  logic [2:0] in_i,
  output logic       fire_o
);

  localparam logic [RUN_W-1:0] DEB_R = RUN_W'(DEBOUNCE);
  localparam logic [RUN_W-1:0] ONE_R = RUN_W'(1);

  logic [2:0]       s_q;
  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             det;

  assign det     = maj3(s_q);
  assign run_inc = run_q + ONE_R;

  // Sample register, state and run counter; everything holds while en_i=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      state_q <= IDLE;
      run_q   <= '0;
    end else if (clear_i) begin
      s_q     <= '0;
      state_q <= IDLE;
      run_q   <= '0;
    end else if (en_i) begin
      s_q     <= in_i;
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next state, run length and fire pulse; only meaningful when en_i=1.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    fire_o  = 1'b0;
    if (en_i) begin
      unique case (state_q)
        IDLE: if (det) begin
          run_d = ONE_R;
          if (DEBOUNCE == 1) begin
            fire_o  = 1'b1;
            state_d = ACTIVE;
          end else begin
            state_d = ARM;
          end
        end
        ARM: if (det) begin
          run_d = run_inc;
          if (run_inc == DEB_R) begin
            fire_o  = 1'b1;
            state_d = ACTIVE;
          end
        end else begin
          // glitch shorter than DEBOUNCE: drop it without an event
          run_d   = '0;
          state_d = IDLE;
        end
        ACTIVE: if (!det) begin
          run_d   = ONE_R;
          state_d = (DEBOUNCE == 1) ? IDLE : RELEASE;
        end
        RELEASE: if (!det) begin
          run_d = run_inc;
          if (run_inc == DEB_R) state_d = IDLE;
        end else begin
          run_d   = '0;
          state_d = ACTIVE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pair_triple_event_counter.sv
// Counts debounced 2-of-3 majority events in a saturating counter and
// reports each new count over a valid/ready channel, newest value wins.
module pair_triple_event_counter
  import pair_triple_event_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         in0_i,
  input  logic                         in1_i,
  input  logic                         in2_i,
  pair_triple_event_counter_if.master  rpt,
  output logic [CNT_W-1:0]             count_o,
  output logic                         saturated_o,
  output logic                         dropped_o
);

  if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_deb
    $error("DEBOUNCE out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             fire;
  logic [CNT_W-1:0] count_q, count_d, cnt_inc;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_val_q, out_val_d;
  logic             sat_q, sat_d;
  logic             drop_q, drop_d;

  pair_triple_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .clear_i (clear_i),
    .in_i    ({in2_i, in1_i, in0_i}),
    .fire_o  (fire)
  );

  assign cnt_inc = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);

  // Counter, report register and sticky flags next state.
  always_comb begin
    count_d     = count_q;
    out_count_d = out_count_q;
    out_val_d   = out_val_q;
    sat_d       = sat_q;
    drop_d      = drop_q;
    if (fire) begin
      count_d     = cnt_inc;
      out_count_d = cnt_inc;
      out_val_d   = 1'b1;
      if (cnt_inc == CNT_MAX) sat_d = 1'b1;
      // pending report not taken this edge is lost to the newer one
      if (out_val_q && !rpt.out_rdy) drop_d = 1'b1;
    end else if (out_val_q && rpt.out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  // Report-side state; clear has priority over everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      out_count_q <= '0;
      out_val_q   <= 1'b0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else if (clear_i) begin
      count_q     <= '0;
      out_count_q <= '0;
      out_val_q   <= 1'b0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_count_q <= out_count_d;
      out_val_q   <= out_val_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
    end
  end

  assign rpt.out_val   = out_val_q;
  assign rpt.out_count = out_count_q;
  assign count_o       = count_q;
  assign saturated_o   = sat_q;
  assign dropped_o     = drop_q;

endmodule

// File: tb/tb_pair_triple_event_counter.sv
// Scenario bench for pair_triple_event_counter (DEBOUNCE=3, CNT_W=4).
// Expected report counts are queued when the qualifying stimulus is driven
// and popped whenever the DUT completes a handshake.
module tb_pair_triple_event_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic [2:0] in_v;
  logic [3:0] count;
  logic       saturated;
  logic       dropped;

  int         tests_run;
  int         tests_failed;
  logic [3:0] exp_q[$];

  pair_triple_event_counter_if #(.CNT_W(4)) dut_if ();

  pair_triple_event_counter #(.DEBOUNCE(3), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .clear_i     (clear),
    .in0_i       (in_v[0]),
    .in1_i       (in_v[1]),
    .in2_i       (in_v[2]),
    .rpt         (dut_if.master),
    .count_o     (count),
    .saturated_o (saturated),
    .dropped_o   (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // One clock: scoreboard a handshake completing at the coming edge, then
  // advance to the next falling edge where inputs change and outputs are read.
  task automatic cycle();
    logic [3:0] e;
    if (rst_n && !clear && dut_if.out_val && dut_if.out_rdy) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected got %0d exp none", dut_if.out_count);
      end else begin
        e = exp_q.pop_front();
        if (dut_if.out_count !== e) begin
          tests_failed++;
          $display("FAIL sb_report got %0d exp %0d", dut_if.out_count, e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    in_v = 3'b000; en = 1'b1; clear = 1'b0; dut_if.out_rdy = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_v = 3'b111; en = 1'b1; dut_if.out_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dut_if.out_val, dut_if.out_count, count, saturated, dropped} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got val=%0b oc=%0d cnt=%0d sat=%0b drop=%0b exp all 0",
               dut_if.out_val, dut_if.out_count, count, saturated, dropped);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    in_v = 3'b011;
    exp_q.push_back(4'd1);
    cycles(3);
    tests_run++;
    if (dut_if.out_val !== 1'b0) begin
      tests_failed++; $display("FAIL basic_early got %0b exp 0", dut_if.out_val);
    end
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b1 || dut_if.out_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL basic_event got val=%0b oc=%0d exp val=1 oc=1", dut_if.out_val, dut_if.out_count);
    end
    dut_if.out_rdy = 1'b1;
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b0 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL basic_accept got val=%0b cnt=%0d exp val=0 cnt=1", dut_if.out_val, count);
    end
    cycle();
    in_v = 3'b000;
    cycles(5);
    tests_run++;
    if (count !== 4'd1 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL basic_hold got cnt=%0d q=%0d exp cnt=1 q=0", count, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    dut_if.out_rdy = 1'b1;
    in_v = 3'b110;
    cycles(2);
    in_v = 3'b000;
    cycles(6);
    tests_run++;
    if (dut_if.out_val !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL glitch_pair got val=%0b cnt=%0d exp val=0 cnt=0", dut_if.out_val, count);
    end
    in_v = 3'b100;
    cycles(10);
    tests_run++;
    if (dut_if.out_val !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL glitch_single got val=%0b cnt=%0d exp val=0 cnt=0", dut_if.out_val, count);
    end
  endtask

  task automatic test_release();
    apply_reset();
    dut_if.out_rdy = 1'b1;
    in_v = 3'b111; exp_q.push_back(4'd1);
    cycles(5);
    in_v = 3'b000; cycles(2);
    in_v = 3'b111; cycles(1);
    in_v = 3'b000; cycles(3);
    in_v = 3'b111; exp_q.push_back(4'd2);
    cycles(3);
    in_v = 3'b000;
    cycles(6);
    tests_run++;
    if (count !== 4'd2 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL release_count got cnt=%0d q=%0d exp cnt=2 q=0", count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    in_v = 3'b111; cycles(4);
    in_v = 3'b000; cycles(4);
    in_v = 3'b111; exp_q.push_back(4'd2);
    cycles(4);
    tests_run++;
    if (dut_if.out_val !== 1'b1 || dut_if.out_count !== 4'd2 || dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_overwrite got val=%0b oc=%0d drop=%0b exp val=1 oc=2 drop=1",
               dut_if.out_val, dut_if.out_count, dropped);
    end
    in_v = 3'b000; cycles(4);
    in_v = 3'b111; cycles(3);
    tests_run++;
    if (dut_if.out_count !== 4'd2) begin
      tests_failed++; $display("FAIL bp_stable got %0d exp 2", dut_if.out_count);
    end
    dut_if.out_rdy = 1'b1;
    exp_q.push_back(4'd3);
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b1 || dut_if.out_count !== 4'd3 || dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_coincident got val=%0b oc=%0d drop=%0b exp val=1 oc=3 drop=1",
               dut_if.out_val, dut_if.out_count, dropped);
    end
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL bp_drain got val=%0b q=%0d exp val=0 q=0", dut_if.out_val, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    dut_if.out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_v = 3'b111;
      exp_q.push_back((i < 15) ? 4'(i + 1) : 4'd15);
      cycles(4);
      if (i == 15) begin
        tests_run++;
        if (dut_if.out_val !== 1'b1 || dut_if.out_count !== 4'd15) begin
          tests_failed++;
          $display("FAIL sat_report got val=%0b oc=%0d exp val=1 oc=15", dut_if.out_val, dut_if.out_count);
        end
      end
      in_v = 3'b000;
      cycles(4);
    end
    tests_run++;
    if (count !== 4'd15 || saturated !== 1'b1 || dropped !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sat_state got cnt=%0d sat=%0b drop=%0b q=%0d exp cnt=15 sat=1 drop=0 q=0",
               count, saturated, dropped, exp_q.size());
    end
    clear = 1'b1; cycle(); clear = 1'b0;
    exp_q.delete();
    tests_run++;
    if ({dut_if.out_val, dut_if.out_count, count, saturated, dropped} !== 11'd0) begin
      tests_failed++;
      $display("FAIL sat_clear got val=%0b oc=%0d cnt=%0d sat=%0b drop=%0b exp all 0",
               dut_if.out_val, dut_if.out_count, count, saturated, dropped);
    end
  endtask

  task automatic test_reset_mid_arm();
    apply_reset();
    in_v = 3'b111; cycles(4);
    in_v = 3'b000; cycles(4);
    in_v = 3'b111; cycles(2);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dut_if.out_val, dut_if.out_count, count, saturated, dropped} !== 11'd0) begin
      tests_failed++;
      $display("FAIL midarm_reset got val=%0b oc=%0d cnt=%0d sat=%0b drop=%0b exp all 0",
               dut_if.out_val, dut_if.out_count, count, saturated, dropped);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd1);
    cycles(3);
    tests_run++;
    if (dut_if.out_val !== 1'b0) begin
      tests_failed++; $display("FAIL midarm_restart got %0b exp 0", dut_if.out_val);
    end
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b1 || count !== 4'd1) begin
      tests_failed++; $display("FAIL midarm_event got val=%0b cnt=%0d exp val=1 cnt=1", dut_if.out_val, count);
    end
    dut_if.out_rdy = 1'b1; cycle();
  endtask

  task automatic test_en_stall();
    apply_reset();
    in_v = 3'b111;
    exp_q.push_back(4'd1);
    cycles(2);
    en = 1'b0;
    cycles(5);
    en = 1'b1;
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b0 || count !== 4'd0) begin
      tests_failed++; $display("FAIL en_early got val=%0b cnt=%0d exp val=0 cnt=0", dut_if.out_val, count);
    end
    cycle();
    tests_run++;
    if (dut_if.out_val !== 1'b1 || dut_if.out_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL en_delayed got val=%0b oc=%0d exp val=1 oc=1", dut_if.out_val, dut_if.out_count);
    end
    dut_if.out_rdy = 1'b1; cycle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL en_drain got q=%0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; en = 1'b1; clear = 1'b0; in_v = 3'b000; dut_if.out_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_release();
    test_back_to_back();
    test_saturation();
    test_reset_mid_arm();
    test_en_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
